// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles,
// with architectural HI/LO registers that MTHI/MTLO can also write while the unit is idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic               is_div, neg_lo, neg_hi, b_zero;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;

  logic               accept, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign accept    = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // Multiply keeps {partial product, remaining multiplier bits} in acc and shifts right;
  // divide keeps {partial remainder, remaining dividend / quotient bits} and shifts left.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_step = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // A zero divisor leaves the dividend magnitude as remainder, so HI naturally equals a.
  assign prod_fix = neg_lo ? -acc : acc;
  assign quot_fix = b_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      b_zero      <= 1'b0;
      acc         <= '0;
      opnd        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= (state == FIX);
      if (state == IDLE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
      if (accept) begin
        is_div      <= op[1];
        neg_lo      <= a_neg ^ b_neg;
        neg_hi      <= a_neg;
        b_zero      <= (b == '0);
        acc         <= {{WIDTH{1'b0}}, mag_a};
        opnd        <= mag_b;
        count       <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end
      if (state == RUN) begin
        acc   <= is_div ? div_step : mul_step;
        count <= count - 1'b1;
      end
      if (state == FIX) begin
        if (is_div) begin
          hi          <= rem_fix;
          lo          <= quot_fix;
          div_by_zero <= b_zero;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule
